pwm_deadtime_driver: RTL and testbench

Complementary gate-drive stage that consumes the registered single-bit PWM output of the duty-cycle controller and produces non-overlapping high-side and low-side drive signals separated by a programmable dead time. It sits directly downstream of the PWM generator and ahead of the output pins. It also provides an enable and a latched fault shutdown.

---
 rtl/pwm_deadtime_driver.sv | 179 +++++++++++++++++
 tb/tb_pwm_deadtime_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_driver.sv
// pwm_deadtime_driver
// Complementary gate-drive stage. It takes the registered PWM bit from the
// duty-cycle controller and drives non-overlapping high-side and low-side
// outputs. A programmable dead time separates the two outputs. The block
// also has a level enable and, optionally, a latched fault shutdown.
//
// Build option:
//   PWM_FAULT_EN  when defined, the block includes the fault_in synchroniser,
//                 the FAULT state and fault_clr handling. When undefined,
//                 fault_in and fault_clr are ignored and fault_flag is 0.
//
// Ports:
//   clk         system clock; all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   pwm_in      PWM from the upstream controller (already synchronous to clk)
//   en          drive enable, level-sensitive
//   dt_cycles   dead time in clk cycles; 0 behaves as 1
//   fault_in    asynchronous external fault (2-FF synchronised)
//   fault_clr   synchronous fault-clear pulse
//   hi_out      high-side drive (registered)
//   lo_out      low-side drive (registered)
//   in_dead     high during a dead interval (registered)
//   fault_flag  high while latched in FAULT (registered)

module pwm_deadtime_driver #(
  parameter int unsigned DT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_in,
  input  logic                en,
  input  logic [DT_WIDTH-1:0] dt_cycles,
  input  logic                fault_in,
  input  logic                fault_clr,
  output logic                hi_out,
  output logic                lo_out,
  output logic                in_dead,
  output logic                fault_flag
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_LOW     = 3'd1,
    S_DEAD_LH = 3'd2,
    S_HIGH    = 3'd3,
`ifdef PWM_FAULT_EN
    S_DEAD_HL = 3'd4,
    S_FAULT   = 3'd5
`else
    S_DEAD_HL = 3'd4
`endif
  } state_t;

  state_t              state, state_d;
  logic [DT_WIDTH-1:0] cnt, cnt_d;
  logic [DT_WIDTH-1:0] dt_load;
  logic                hi_d, lo_d, dead_d, fault_d;

`ifdef PWM_FAULT_EN
  logic fault_meta;
  logic fault_s;

  // Two-flop synchroniser for the asynchronous fault input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_meta <= 1'b0;
      fault_s    <= 1'b0;
    end else begin
      fault_meta <= fault_in;
      fault_s    <= fault_meta;
    end
  end
`else
  // Fault inputs have no function in this build
  logic unused_fault_inputs;
  assign unused_fault_inputs = fault_in ^ fault_clr;
`endif

  // Counter reload: max(dt_cycles,1)-1, so that the dead interval ends on the edge that reads 0
  always_comb begin
    if (dt_cycles == '0) begin
      dt_load = '0;
    end else begin
      dt_load = dt_cycles - DT_WIDTH'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OFF;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state, dead-time counter and next output values
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_d    = 1'b0;
    lo_d    = 1'b0;
    dead_d  = 1'b0;
    fault_d = 1'b0;

`ifdef PWM_FAULT_EN
    if (fault_s) begin
      state_d = S_FAULT;
      cnt_d   = '0;
    end else if (state == S_FAULT) begin
      if (fault_clr) begin
        state_d = S_OFF;
      end
    end else
`endif
    if (!en) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state)
        // A dead interval always comes before the first conduction after enable
        S_OFF: begin
          state_d = pwm_in ? S_DEAD_LH : S_DEAD_HL;
          cnt_d   = dt_load;
        end
        S_LOW: begin
          if (pwm_in) begin
            state_d = S_DEAD_LH;
            cnt_d   = dt_load;
          end
        end
        S_HIGH: begin
          if (!pwm_in) begin
            state_d = S_DEAD_HL;
            cnt_d   = dt_load;
          end
        end
        // The interval always runs to the end; pwm_in at expiry picks the side that conducts next
        S_DEAD_LH, S_DEAD_HL: begin
          if (cnt == '0) begin
            state_d = pwm_in ? S_HIGH : S_LOW;
          end else begin
            cnt_d = cnt - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the state being entered, so they change on the same edge as the state
    hi_d   = (state_d == S_HIGH);
    lo_d   = (state_d == S_LOW);
    dead_d = (state_d == S_DEAD_LH) || (state_d == S_DEAD_HL);
`ifdef PWM_FAULT_EN
    fault_d = (state_d == S_FAULT);
`endif
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_out     <= 1'b0;
      lo_out     <= 1'b0;
      in_dead    <= 1'b0;
      fault_flag <= 1'b0;
    end else begin
      hi_out     <= hi_d;
      lo_out     <= lo_d;
      in_dead    <= dead_d;
      fault_flag <= fault_d;
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Self-checking bench for pwm_deadtime_driver. It drives directed scenarios
// and then randomized ones, and compares the DUT every cycle against a
// behavioural model that tracks the remaining dead cycles.
module tb_pwm_deadtime_driver;

  localparam int unsigned DT_WIDTH = 4;
`ifdef PWM_FAULT_EN
  localparam bit FAULT_BUILD = 1'b1;
`else
  localparam bit FAULT_BUILD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                pwm_in;
  logic                en;
  logic [DT_WIDTH-1:0] dt_cycles;
  logic                fault_in;
  logic                fault_clr;
  logic                hi_out, lo_out, in_dead, fault_flag;

  int errors = 0;
  int checks = 0;

  // Model state: off / fault flags, dead cycles still to serve, last conducting side
  bit       m_off;
  bit       m_fault;
  bit       m_side;
  int       m_dead;
  bit [1:0] m_sync;

  pwm_deadtime_driver #(.DT_WIDTH(DT_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .en         (en),
    .dt_cycles  (dt_cycles),
    .fault_in   (fault_in),
    .fault_clr  (fault_clr),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .in_dead    (in_dead),
    .fault_flag (fault_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_off   = 1'b1;
    m_fault = 1'b0;
    m_side  = 1'b0;
    m_dead  = 0;
    m_sync  = 2'b00;
  endtask

  // One clock edge of the reference behaviour, using the inputs held across the edge
  task automatic model_edge();
    bit fs_now;
    int eff_dt;
    fs_now = FAULT_BUILD && m_sync[1];
    m_sync = {m_sync[0], fault_in};
    eff_dt = (dt_cycles == 0) ? 1 : int'(dt_cycles);
    if (fs_now) begin
      m_fault = 1'b1;
      m_dead  = 0;
    end else if (m_fault) begin
      if (fault_clr) begin
        m_fault = 1'b0;
        m_off   = 1'b1;
      end
    end else if (!en) begin
      m_off  = 1'b1;
      m_dead = 0;
    end else if (m_off) begin
      m_off  = 1'b0;
      m_dead = eff_dt;
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) m_side = pwm_in;
    end else if (pwm_in != m_side) begin
      m_dead = eff_dt;
    end
  endtask

  task automatic compare_all();
    bit live;
    live = !m_fault && !m_off;
    check("hi_out",     hi_out,     32'(live && m_dead == 0 && m_side));
    check("lo_out",     lo_out,     32'(live && m_dead == 0 && !m_side));
    check("in_dead",    in_dead,    32'(live && m_dead > 0));
    check("fault_flag", fault_flag, 32'(m_fault));
    check("overlap",    32'(hi_out & lo_out), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  int hi_cnt, lo_cnt, dead_cnt;
  int period, high_len, seg_len;

  initial begin
    rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0; dt_cycles = '0;
    fault_in = 1'b0; fault_clr = 1'b0;
    model_reset();
    #1;
    check("rst_hi",    hi_out,     32'd0);
    check("rst_lo",    lo_out,     32'd0);
    check("rst_dead",  in_dead,    32'd0);
    check("rst_fault", fault_flag, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Enable with pwm low, dt=2: two dead cycles then low side conducts
    en = 1'b1; pwm_in = 1'b0; dt_cycles = 4'd2;
    step(); check("tp1_dead0", in_dead, 32'd1);
    step(); check("tp1_dead1", in_dead, 32'd1);
    step(); check("tp1_lo", lo_out, 32'd1);
    check("tp1_hi", hi_out, 32'd0);

    // 50% upstream pattern, period 10, dt=2: 3 hi, 3 lo, 4 dead cycles per period
    hi_cnt = 0; lo_cnt = 0; dead_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      pwm_in = ((c % 10) < 5);
      step();
      if (c >= 20) begin
        hi_cnt   += int'(hi_out);
        lo_cnt   += int'(lo_out);
        dead_cnt += int'(in_dead);
      end
    end
    check("p50_hi",   hi_cnt,   32'd12);
    check("p50_lo",   lo_cnt,   32'd12);
    check("p50_dead", dead_cnt, 32'd16);

    // dt=0 (one dead cycle) and dt=15 against a 10-cycle period
    dt_cycles = 4'd0;
    for (int c = 0; c < 40; c++) begin pwm_in = ((c % 6) < 3); step(); end
    dt_cycles = 4'd15;
    for (int c = 0; c < 80; c++) begin pwm_in = ((c % 10) < 5); step(); end

`ifdef PWM_FAULT_EN
    // Fault during HIGH: outputs drop two edges after the first sample
    dt_cycles = 4'd1; pwm_in = 1'b1;
    for (int c = 0; c < 20; c++) step();
    fault_in = 1'b1;
    step(); check("flt_hi_e0", hi_out, 32'd1);
    step(); check("flt_hi_e1", hi_out, 32'd1);
    step(); check("flt_hi_e2", hi_out, 32'd0); check("flt_flag_e2", fault_flag, 32'd1);
    fault_clr = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("flt_clr_ignored", fault_flag, 32'd1);
    fault_clr = 1'b0; fault_in = 1'b0;
    for (int c = 0; c < 3; c++) step();
    fault_clr = 1'b1;
    step(); check("flt_cleared", fault_flag, 32'd0); check("flt_off_hi", hi_out, 32'd0);
    fault_clr = 1'b0;
    step(); check("flt_redead", in_dead, 32'd1);
    for (int c = 0; c < 5; c++) step();
`else
    // Fault inputs must have no effect in this build
    for (int c = 0; c < 40; c++) begin
      fault_in = c[2]; fault_clr = c[0];
      step();
      check("nofault_flag", fault_flag, 32'd0);
    end
    fault_in = 1'b0; fault_clr = 1'b0;
`endif

    // en dropped mid DEAD_LH, then re-enabled: full dead interval before hi
    dt_cycles = 4'd4; pwm_in = 1'b0;
    for (int c = 0; c < 10; c++) step();
    pwm_in = 1'b1;
    step(); check("en_dlh", in_dead, 32'd1);
    step();
    en = 1'b0;
    step(); check("en_off_dead", in_dead, 32'd0); check("en_off_hi", hi_out, 32'd0);
    step();
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin step(); check("en_re_dead", in_dead, 32'd1); end
    step(); check("en_re_hi", hi_out, 32'd1);

    // Asynchronous reset during a dead interval
    pwm_in = 1'b0;
    for (int c = 0; c < 8; c++) step();
    pwm_in = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check("amid_dead", in_dead, 32'd0);
    check("amid_hi",   hi_out,  32'd0);
    check("amid_lo",   lo_out,  32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) step();

    // Randomized segments: duty (0%..100%), dead time, enable drops, faults, clears
    for (int s = 0; s < 40; s++) begin
      period    = $urandom_range(24, 2);
      high_len  = $urandom_range(period, 0);
      seg_len   = $urandom_range(80, 20);
      dt_cycles = DT_WIDTH'($urandom_range(15, 0));
      for (int c = 0; c < seg_len; c++) begin
        pwm_in    = ((c % period) < high_len);
        en        = ($urandom_range(40, 0) != 0);
        if ($urandom_range(9, 0) == 0) dt_cycles = DT_WIDTH'($urandom_range(15, 0));
        if ($urandom_range(60, 0) == 0) fault_in = ~fault_in;
        fault_clr = ($urandom_range(7, 0) == 0);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
